// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: one outstanding access, alignment checks,
// byte-lane steering, load extraction/extension and a bounded WAIT timeout.
module lsu_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_load,
    input  logic                req_store,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W-1:0]   req_alu_data,
    input  logic [4:0]          req_rd,
    input  logic                req_wb_en,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W/8-1:0] mem_req_be,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata,
    input  logic                mem_rsp_err,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [DATA_W-1:0]   wb_data,
    output logic                wb_enable,
    output logic                busy,
    output logic                exc_valid,
    output logic [1:0]          exc_code,
    output logic [ADDR_W-1:0]   exc_addr
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t r_state, w_next;

    logic              r_we, r_unsigned;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [4:0]        r_rd;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_wb_valid, r_wb_enable, r_exc_valid;
    logic [4:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic [1:0]        r_exc_code;
    logic [ADDR_W-1:0] r_exc_addr;

    logic              w_accept, w_is_mem, w_misalign, w_illegal, w_bad, w_go;
    logic              w_rsp, w_timeout;
    logic [OFF_W-1:0]  w_off;
    logic [BE_W-1:0]   w_mask;
    logic [DATA_W-1:0] w_field, w_load;

    assign req_ready = (r_state == S_IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;
    assign w_is_mem  = req_load || req_store;
    assign w_illegal = (req_size == 2'd3) && (DATA_W == 32);

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'd1:    w_misalign = req_addr[0];
            2'd2:    w_misalign = |req_addr[1:0];
            2'd3:    w_misalign = |req_addr[2:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_bad = w_is_mem && (w_misalign || w_illegal);
    assign w_go  = w_accept && w_is_mem && !w_bad;
    assign w_rsp = (r_state == S_WAIT) && mem_rsp_valid;

    // A response on the last allowed WAIT cycle wins over the timeout.
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_state == S_WAIT) && !mem_rsp_valid &&
                               (r_cnt == CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_REQ;
            S_REQ:   if (mem_req_ready) w_next = S_WAIT;
            S_WAIT:  if (w_rsp || w_timeout) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || r_state != S_WAIT) r_cnt <= '0;
        else                            r_cnt <= r_cnt + CNT_W'(1);
    end

    // A load+store request is a load, so only req_load decides the direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rd       <= 5'd0;
        end else if (w_go) begin
            r_we       <= !req_load;
            r_unsigned <= req_unsigned;
            r_size     <= req_size;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rd       <= req_rd;
        end
    end

    assign w_off = r_addr[OFF_W-1:0];

    always_comb begin
        w_mask = '1;
        case (r_size)
            2'd0:    w_mask = BE_W'(1);
            2'd1:    w_mask = BE_W'(3);
            2'd2:    w_mask = BE_W'(15);
            default: w_mask = '1;
        endcase
    end

    always_comb begin
        mem_req_wdata = r_wdata;
        case (r_size)
            2'd0:    mem_req_wdata = {BE_W{r_wdata[7:0]}};
            2'd1:    mem_req_wdata = {(BE_W/2){r_wdata[15:0]}};
            2'd2:    mem_req_wdata = {(BE_W/4){r_wdata[31:0]}};
            default: mem_req_wdata = r_wdata;
        endcase
    end

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_we    = r_we;
    assign mem_req_addr  = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign mem_req_be    = r_we ? (w_mask << w_off) : '0;

    assign w_field = mem_rsp_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load = w_field;
        case (r_size)
            2'd0: w_load = r_unsigned ? DATA_W'(w_field[7:0])  : DATA_W'($signed(w_field[7:0]));
            2'd1: w_load = r_unsigned ? DATA_W'(w_field[15:0]) : DATA_W'($signed(w_field[15:0]));
            2'd2: w_load = r_unsigned ? DATA_W'(w_field[31:0]) : DATA_W'($signed(w_field[31:0]));
            default: w_load = w_field;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid  <= 1'b0;
            r_wb_enable <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= '0;
            r_exc_valid <= 1'b0;
            r_exc_code  <= 2'b00;
            r_exc_addr  <= '0;
        end else begin
            r_wb_valid  <= 1'b0;
            r_exc_valid <= 1'b0;
            if (w_accept && !w_is_mem) begin
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= req_rd;
                r_wb_data   <= req_alu_data;
                r_wb_enable <= req_wb_en && (req_rd != 5'd0);
            end else if (w_accept && w_bad) begin
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= req_rd;
                r_wb_data   <= '0;
                r_wb_enable <= 1'b0;
                r_exc_valid <= 1'b1;
                r_exc_code  <= 2'b01;
                r_exc_addr  <= req_addr;
            end else if (w_rsp) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                if (mem_rsp_err) begin
                    r_wb_data   <= '0;
                    r_wb_enable <= 1'b0;
                    r_exc_valid <= 1'b1;
                    r_exc_code  <= 2'b10;
                    r_exc_addr  <= r_addr;
                end else begin
                    r_wb_data   <= r_we ? '0 : w_load;
                    r_wb_enable <= !r_we && (r_rd != 5'd0);
                end
            end else if (w_timeout) begin
                r_wb_valid  <= 1'b1;
                r_wb_rd     <= r_rd;
                r_wb_data   <= '0;
                r_wb_enable <= 1'b0;
                r_exc_valid <= 1'b1;
                r_exc_code  <= 2'b11;
                r_exc_addr  <= r_addr;
            end
        end
    end

    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign wb_enable = r_wb_enable;
    assign exc_valid = r_exc_valid;
    assign exc_code  = r_exc_code;
    assign exc_addr  = r_exc_addr;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a 32-bit instance (TIMEOUT=4) and a 64-bit instance
// (TIMEOUT=6) driven by directed and random transactions against a byte-level model.
module tb_lsu_mem_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // index 0: DATA_W=32, TIMEOUT=4; index 1: DATA_W=64, TIMEOUT=6
    logic        i_valid [2], i_load [2], i_store [2], i_uns [2], i_wb_en [2];
    logic        i_mready [2], i_rvalid [2], i_rerr [2];
    logic [1:0]  i_size [2];
    logic [31:0] i_addr [2];
    logic [63:0] i_wdata [2], i_alu [2], i_rdata [2];
    logic [4:0]  i_rd [2];

    logic        o_ready [2], o_mvalid [2], o_mwe [2], o_wbv [2], o_wben [2], o_busy [2], o_excv [2];
    logic [31:0] o_maddr [2], o_exca [2];
    logic [4:0]  o_wbrd [2];
    logic [1:0]  o_excc [2];
    logic [63:0] o_be [2], o_mwdata [2], o_wbdata [2];

    logic [3:0]  be0;
    logic [7:0]  be1;
    logic [31:0] mwd0, wbd0;
    logic [63:0] mwd1, wbd1;
    assign o_be[0]     = {60'h0, be0};
    assign o_be[1]     = {56'h0, be1};
    assign o_mwdata[0] = {32'h0, mwd0};
    assign o_mwdata[1] = mwd1;
    assign o_wbdata[0] = {32'h0, wbd0};
    assign o_wbdata[1] = wbd1;

    lsu_mem_stage #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
        .clk(clk), .reset(reset),
        .req_valid(i_valid[0]), .req_ready(o_ready[0]), .req_load(i_load[0]), .req_store(i_store[0]),
        .req_size(i_size[0]), .req_unsigned(i_uns[0]), .req_addr(i_addr[0]),
        .req_wdata(i_wdata[0][31:0]), .req_alu_data(i_alu[0][31:0]), .req_rd(i_rd[0]),
        .req_wb_en(i_wb_en[0]),
        .mem_req_valid(o_mvalid[0]), .mem_req_ready(i_mready[0]), .mem_req_we(o_mwe[0]),
        .mem_req_addr(o_maddr[0]), .mem_req_be(be0), .mem_req_wdata(mwd0),
        .mem_rsp_valid(i_rvalid[0]), .mem_rsp_rdata(i_rdata[0][31:0]), .mem_rsp_err(i_rerr[0]),
        .wb_valid(o_wbv[0]), .wb_rd(o_wbrd[0]), .wb_data(wbd0), .wb_enable(o_wben[0]),
        .busy(o_busy[0]), .exc_valid(o_excv[0]), .exc_code(o_excc[0]), .exc_addr(o_exca[0]));

    lsu_mem_stage #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(6)) u_dut64 (
        .clk(clk), .reset(reset),
        .req_valid(i_valid[1]), .req_ready(o_ready[1]), .req_load(i_load[1]), .req_store(i_store[1]),
        .req_size(i_size[1]), .req_unsigned(i_uns[1]), .req_addr(i_addr[1]),
        .req_wdata(i_wdata[1]), .req_alu_data(i_alu[1]), .req_rd(i_rd[1]),
        .req_wb_en(i_wb_en[1]),
        .mem_req_valid(o_mvalid[1]), .mem_req_ready(i_mready[1]), .mem_req_we(o_mwe[1]),
        .mem_req_addr(o_maddr[1]), .mem_req_be(be1), .mem_req_wdata(mwd1),
        .mem_rsp_valid(i_rvalid[1]), .mem_rsp_rdata(i_rdata[1]), .mem_rsp_err(i_rerr[1]),
        .wb_valid(o_wbv[1]), .wb_rd(o_wbrd[1]), .wb_data(wbd1), .wb_enable(o_wben[1]),
        .busy(o_busy[1]), .exc_valid(o_excv[1]), .exc_code(o_excc[1]), .exc_addr(o_exca[1]));

    logic [63:0] cap_maddr, cap_be, cap_mwdata, cap_wbdata, cap_wben;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: byte-lane arithmetic on a DATA_W/8-byte memory word ----
    function automatic int nbytes(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    function automatic bit m_bad(input int k, input logic [1:0] sz, input logic [31:0] a);
        return ((a % (32'd1 << sz)) != 0) || (sz == 2'd3 && k == 0);
    endfunction

    function automatic logic [63:0] m_be(input int k, input logic [1:0] sz, input logic [31:0] a, input bit we);
        int off = int'(a % nbytes(k));
        if (!we) return 64'h0;
        return ((64'd1 << (1 << sz)) - 64'd1) << off;
    endfunction

    function automatic logic [63:0] m_wdata(input int k, input logic [1:0] sz, input logic [63:0] wd);
        int bits = 8 << sz;
        logic [63:0] lane = (bits == 64) ? wd : (wd & ((64'd1 << bits) - 64'd1));
        logic [63:0] r = 64'h0;
        for (int i = 0; i < nbytes(k) * 8 / bits; i++) r |= lane << (i * bits);
        return r;
    endfunction

    function automatic logic [63:0] m_load(input int k, input logic [1:0] sz, input bit uns,
                                           input logic [31:0] a, input logic [63:0] rdat);
        int bits = 8 << sz;
        int off = int'(a % nbytes(k));
        logic [63:0] src = (k == 0) ? {32'h0, rdat[31:0]} : rdat;
        logic [63:0] mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        logic [63:0] v = (src >> (8 * off)) & mask;
        if (!uns && v[bits-1]) v |= ~mask;
        if (k == 0) v &= 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic clear_inputs(input int k);
        i_valid[k] = 0; i_load[k] = 0; i_store[k] = 0; i_uns[k] = 0; i_wb_en[k] = 0;
        i_mready[k] = 0; i_rvalid[k] = 0; i_rerr[k] = 0; i_size[k] = 0; i_addr[k] = 0;
        i_wdata[k] = 0; i_alu[k] = 0; i_rdata[k] = 0; i_rd[k] = 0;
    endtask

    task automatic do_alu(input int k, input logic [63:0] alu, input logic [4:0] rd, input bit en);
        logic [63:0] exp = (k == 0) ? {32'h0, alu[31:0]} : alu;
        i_valid[k] = 1; i_load[k] = 0; i_store[k] = 0; i_alu[k] = alu; i_rd[k] = rd;
        i_wb_en[k] = en; i_size[k] = 2'd3; i_addr[k] = 32'h7;
        step();
        i_valid[k] = 0;
        #1;
        chk("alu wb_valid", o_wbv[k], 1);
        chk("alu wb_data", o_wbdata[k], exp);
        chk("alu wb_rd", o_wbrd[k], rd);
        chk("alu wb_enable", o_wben[k], en && rd != 0);
        chk("alu exc_valid", o_excv[k], 0);
        chk("alu busy", o_busy[k], 0);
        step();
        chk("alu wb pulse", o_wbv[k], 0);
    endtask

    task automatic do_mem(input int k, input bit ld, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [31:0] a, input logic [63:0] wd, input logic [63:0] rdat,
                          input logic [4:0] rd, input int rdy_dly, input int rsp_dly, input bit err);
        bit we = !ld;
        logic [63:0] exp_be = m_be(k, sz, a, we);
        logic [63:0] exp_wd = m_wdata(k, sz, wd);
        logic [63:0] exp_data = ld ? m_load(k, sz, uns, a, rdat) : 64'h0;
        logic [31:0] exp_addr = a & ~32'(nbytes(k) - 1);
        i_valid[k] = 1; i_load[k] = ld; i_store[k] = st; i_size[k] = sz; i_uns[k] = uns;
        i_addr[k] = a; i_wdata[k] = wd; i_rd[k] = rd; i_wb_en[k] = 1;
        i_alu[k] = {$urandom, $urandom};
        #1 chk("req_ready", o_ready[k], 1);
        step();
        i_valid[k] = 0;
        #1;
        if (m_bad(k, sz, a)) begin
            chk("misalign wb_valid", o_wbv[k], 1);
            chk("misalign exc_valid", o_excv[k], 1);
            chk("misalign exc_code", o_excc[k], 2'b01);
            chk("misalign exc_addr", o_exca[k], a);
            chk("misalign wb_enable", o_wben[k], 0);
            chk("misalign mem_req_valid", o_mvalid[k], 0);
            chk("misalign busy", o_busy[k], 0);
            step();
            chk("misalign exc pulse", o_excv[k], 0);
            chk("misalign exc_code hold", o_excc[k], 2'b01);
            return;
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            i_mready[k] = (i == rdy_dly);
            #1;
            chk("mem_req_valid", o_mvalid[k], 1);
            chk("mem_req_we", o_mwe[k], we);
            chk("mem_req_addr", o_maddr[k], exp_addr);
            chk("mem_req_be", o_be[k], exp_be);
            chk("mem_req_wdata", o_mwdata[k], exp_wd);
            chk("busy in REQ", o_busy[k], 1);
            cap_maddr = o_maddr[k]; cap_be = o_be[k]; cap_mwdata = o_mwdata[k];
            step();
        end
        i_mready[k] = 0;
        for (int i = 0; i <= rsp_dly; i++) begin
            i_rvalid[k] = (i == rsp_dly); i_rdata[k] = rdat; i_rerr[k] = err;
            #1;
            chk("WAIT mem_req_valid", o_mvalid[k], 0);
            chk("WAIT wb_valid", o_wbv[k], 0);
            step();
        end
        i_rvalid[k] = 0; i_rerr[k] = 0;
        #1;
        chk("rsp wb_valid", o_wbv[k], 1);
        chk("rsp wb_rd", o_wbrd[k], rd);
        chk("rsp exc_valid", o_excv[k], err);
        chk("rsp busy", o_busy[k], 0);
        if (err) begin
            chk("bus err exc_code", o_excc[k], 2'b10);
            chk("bus err exc_addr", o_exca[k], a);
            chk("bus err wb_enable", o_wben[k], 0);
        end else begin
            chk("rsp wb_data", o_wbdata[k], exp_data);
            chk("rsp wb_enable", o_wben[k], ld && rd != 0);
        end
        cap_wbdata = o_wbdata[k]; cap_wben = {63'h0, o_wben[k]};
        step();
        chk("rsp wb pulse", o_wbv[k], 0);
        if (!err) chk("wb_data hold", o_wbdata[k], exp_data);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] sz;
        logic [31:0] a;
        bit ld, st;
        int k;
        clear_inputs(0);
        clear_inputs(1);
        reset = 1;
        step();
        step();
        for (int j = 0; j < 2; j++) begin
            chk("reset req_ready", o_ready[j], 0);
            chk("reset busy", o_busy[j], 0);
            chk("reset wb_valid", o_wbv[j], 0);
            chk("reset exc_valid", o_excv[j], 0);
            chk("reset mem_req_valid", o_mvalid[j], 0);
            chk("reset wb_data", o_wbdata[j], 0);
            chk("reset exc_code", o_excc[j], 0);
        end
        reset = 0;
        step();

        // LB sign-extended from top byte
        do_mem(0, 1, 0, 2'd0, 0, 32'h1003, 64'h0, 64'h80AABBCC, 5'd3, 0, 1, 0);
        chk("LB mem_req_addr", cap_maddr, 64'h1000);
        chk("LB be", cap_be, 64'h0);
        chk("LB wb_data", cap_wbdata, 64'hFFFF_FF80);
        // SH to upper half
        do_mem(0, 0, 1, 2'd1, 0, 32'h2002, 64'h1234ABCD, 64'h0, 5'd4, 0, 0, 0);
        chk("SH be", cap_be, 64'hC);
        chk("SH wdata", cap_mwdata, 64'hABCD_ABCD);
        chk("SH wb_enable", cap_wben, 64'h0);
        // misaligned word and illegal doubleword on the 32-bit instance
        do_mem(0, 1, 0, 2'd2, 0, 32'h3001, 64'h0, 64'h0, 5'd5, 0, 0, 0);
        do_mem(0, 1, 0, 2'd3, 0, 32'h3008, 64'h0, 64'h0, 5'd5, 0, 0, 0);
        // memory backpressure, load+store treated as load, bus error, rd=0 load
        do_mem(0, 0, 1, 2'd0, 0, 32'h501, 64'h5A, 64'h0, 5'd6, 5, 2, 0);
        do_mem(0, 1, 1, 2'd1, 1, 32'h602, 64'hFFFF, 64'h8001_7777, 5'd7, 1, 0, 0);
        do_mem(0, 1, 0, 2'd2, 0, 32'h700, 64'h0, 64'h1, 5'd8, 0, 1, 1);
        do_mem(0, 1, 0, 2'd2, 0, 32'h704, 64'h0, 64'h1234_5678, 5'd0, 0, 3, 0);

        // non-memory ops back to back, including rd=0
        i_valid[0] = 1; i_load[0] = 0; i_store[0] = 0; i_alu[0] = 64'hCAFE0001; i_rd[0] = 5'd5; i_wb_en[0] = 1;
        step();
        i_alu[0] = 64'hCAFE0002; i_rd[0] = 5'd0;
        #1;
        chk("b2b first wb_data", o_wbdata[0], 64'hCAFE0001);
        chk("b2b first wb_enable", o_wben[0], 1);
        chk("b2b req_ready", o_ready[0], 1);
        step();
        i_valid[0] = 0;
        #1;
        chk("b2b second wb_valid", o_wbv[0], 1);
        chk("b2b second wb_data", o_wbdata[0], 64'hCAFE0002);
        chk("b2b second wb_enable", o_wben[0], 0);
        step();
        do_alu(0, 64'h0000_1111, 5'd9, 0);

        // timeout after 4 WAIT cycles, then a late response
        i_valid[0] = 1; i_load[0] = 1; i_store[0] = 0; i_size[0] = 2'd2; i_addr[0] = 32'h100; i_rd[0] = 5'd7;
        step();
        i_valid[0] = 0; i_mready[0] = 1;
        #1 chk("TO mem_req_valid", o_mvalid[0], 1);
        step();
        i_mready[0] = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("TO busy in WAIT", o_busy[0], 1);
            chk("TO no early exc", o_excv[0], 0);
            step();
        end
        #1;
        chk("TO exc_valid", o_excv[0], 1);
        chk("TO exc_code", o_excc[0], 2'b11);
        chk("TO exc_addr", o_exca[0], 32'h100);
        chk("TO wb_enable", o_wben[0], 0);
        chk("TO busy", o_busy[0], 0);
        i_rvalid[0] = 1; i_rdata[0] = 64'h55;
        step();
        i_rvalid[0] = 0;
        #1;
        chk("late rsp wb_valid", o_wbv[0], 0);
        chk("late rsp exc_valid", o_excv[0], 0);
        chk("late rsp busy", o_busy[0], 0);
        do_alu(0, 64'h0000_2222, 5'd10, 1);

        // 64-bit instance
        do_mem(1, 1, 0, 2'd2, 1, 32'h4004, 64'h0, 64'hDEADBEEF_00000000, 5'd9, 0, 0, 0);
        chk("LWU wb_data", cap_wbdata, 64'h0000_0000_DEAD_BEEF);
        do_mem(1, 1, 0, 2'd2, 0, 32'h4004, 64'h0, 64'hDEADBEEF_00000000, 5'd9, 1, 2, 0);
        do_mem(1, 0, 1, 2'd3, 0, 32'h4008, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd2, 0, 0, 0);
        do_mem(1, 1, 0, 2'd3, 0, 32'h4004, 64'h0, 64'h0, 5'd2, 0, 0, 0);

        // reset while waiting for a response
        i_valid[1] = 1; i_load[1] = 1; i_store[1] = 0; i_size[1] = 2'd2; i_addr[1] = 32'h4000; i_rd[1] = 5'd3;
        step();
        i_valid[1] = 0; i_mready[1] = 1;
        step();
        i_mready[1] = 0;
        step();
        #1 chk("pre-reset busy", o_busy[1], 1);
        reset = 1;
        #1 chk("reset req_ready comb", o_ready[1], 0);
        step();
        #1;
        chk("reset WAIT busy", o_busy[1], 0);
        chk("reset WAIT wb_valid", o_wbv[1], 0);
        chk("reset WAIT exc_valid", o_excv[1], 0);
        chk("reset WAIT wb_data", o_wbdata[1], 0);
        reset = 0;
        i_rvalid[1] = 1; i_rdata[1] = 64'h77;
        step();
        i_rvalid[1] = 0;
        #1;
        chk("post-reset rsp wb_valid", o_wbv[1], 0);
        chk("post-reset busy", o_busy[1], 0);
        step();
        chk("post-reset rsp still quiet", o_wbv[1], 0);

        // random traffic
        for (int n = 0; n < 80; n++) begin
            k = int'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                do_alu(k, {$urandom, $urandom}, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            end else begin
                ld = 1'($urandom_range(0, 1));
                st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
                sz = 2'($urandom_range(0, 3));
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
                do_mem(k, ld, st, sz, 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                       {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       $urandom_range(0, 7) == 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
